mux_rr_scheduler: RTL and testbench

//   Round-robin scheduler that shares the 32:1 x 2-bit input mux between 32 requesters.
//   It arbitrates the req lines, drives the mux sel bus, and captures the selected mux output.
//   It presents the captured data downstream through a valid/ready handshake, tagged with the source index.
//   It sits between the requester array and the consumer, with the mux instanced alongside it.

---
 rtl/mux_sched_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 26 ++
 rtl/mux_rr_scheduler.sv | 67 ++++++
 tb/tb_mux_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants and state encoding for the
// round-robin mux scheduler.
package mux_sched_pkg;
  localparam int NUM_REQ = 32;
  localparam int SEL_W = 5;
  localparam int DATA_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    SEND = 2'd2
  } state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-priority encoder: first set req at or
// after ptr, wrapping mod NUM_REQ.
module rr_priority_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    any = |req;
    idx = ptr;
    // scan high to low so the lowest rotated bit wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ptr + SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a shared 32:1 mux with
// a captured valid/ready output.
module mux_rr_scheduler
  import mux_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  mux_out,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_src
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            sel   <= pick_idx;
            gnt   <= NUM_REQ'(1) << pick_idx;
            state <= CAPT;
          end
        end
        CAPT: begin
          out_data  <= mux_out;
          out_src   <= sel;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            gnt       <= '0;
            ptr       <= sel + SEL_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed self-checking bench for mux_rr_scheduler.
// The shared mux is modelled as inp[sel].
module tb_mux_rr_scheduler;
  import mux_sched_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [DATA_W-1:0]  mux_out;
  logic [SEL_W-1:0]   sel;
  logic [NUM_REQ-1:0] gnt;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DATA_W-1:0]  out_data;
  logic [SEL_W-1:0]   out_src;

  logic [DATA_W-1:0]  inp [NUM_REQ];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux_out = inp[sel];

  mux_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mux_out   (mux_out),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 12) begin
      step();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid timeout, got %0b want 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({sel, gnt, out_valid, out_data, out_src} !== '0) begin
      errors++;
      $display("FAIL reset_init: sel=%0d gnt=%h v=%0b d=%0d src=%0d want all 0",
               sel, gnt, out_valid, out_data, out_src);
    end
    step();
    rst_n = 1'b1;
    req = NUM_REQ'(1) << 3;
    inp[3] = 2'd1;
    out_ready = 1'b0;
    wait_valid("reset_fill");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, gnt, out_valid, out_data, out_src} !== '0) begin
      errors++;
      $display("FAIL reset_async: sel=%0d gnt=%h v=%0b d=%0d src=%0d want all 0",
               sel, gnt, out_valid, out_data, out_src);
    end
    req = '0;
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (gnt !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: gnt=%h v=%0b want 0 0", gnt, out_valid);
    end
  endtask

  task automatic test_single();
    req = NUM_REQ'(1) << 5;
    inp[5] = 2'b10;
    out_ready = 1'b1;
    step();
    checks++;
    if (sel !== 5'd5 || gnt !== 32'h20 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: sel=%0d gnt=%h v=%0b want 5 00000020 0",
               sel, gnt, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'd2 || out_src !== 5'd5) begin
      errors++;
      $display("FAIL single_out: v=%0b d=%0d src=%0d want 1 2 5",
               out_valid, out_data, out_src);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL single_accept: v=%0b gnt=%h want 0 0", out_valid, gnt);
    end
    step();
    checks++;
    if (sel !== 5'd5 || gnt !== 32'h20) begin
      errors++;
      $display("FAIL single_regrant: sel=%0d gnt=%h want 5 00000020", sel, gnt);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_rr_order();
    logic [SEL_W-1:0] exp_src [6];
    exp_src = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd1, 5'd31};
    do_reset();
    req = 32'h8000_0003;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_valid("rr_wait");
      checks++;
      if (out_src !== exp_src[k] || gnt !== (NUM_REQ'(1) << exp_src[k])) begin
        errors++;
        $display("FAIL rr_order[%0d]: src=%0d gnt=%h want src %0d", k,
                 out_src, gnt, exp_src[k]);
      end
      step();
    end
    req = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = NUM_REQ'(1) << 7;
    inp[7] = 2'd1;
    out_ready = 1'b0;
    wait_valid("bp_wait");
    req = '0;
    for (int k = 0; k < 10; k++) begin
      inp[7] = ~inp[7];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 2'd1 || out_src !== 5'd7 ||
          sel !== 5'd7 || gnt !== 32'h80) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%0b d=%0d src=%0d sel=%0d gnt=%h want 1 1 7 7 00000080",
                 k, out_valid, out_data, out_src, sel, gnt);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL bp_accept: v=%0b gnt=%h want 0 0", out_valid, gnt);
    end
  endtask

  task automatic test_withdraw();
    req = NUM_REQ'(1) << 12;
    inp[12] = 2'd3;
    out_ready = 1'b1;
    step();
    checks++;
    if (sel !== 5'd12 || gnt !== 32'h1000) begin
      errors++;
      $display("FAIL wd_grant: sel=%0d gnt=%h want 12 00001000", sel, gnt);
    end
    req = '0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 5'd12 || out_data !== 2'd3) begin
      errors++;
      $display("FAIL wd_out: v=%0b src=%0d d=%0d want 1 12 3",
               out_valid, out_src, out_data);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL wd_idle: v=%0b gnt=%h want 0 0", out_valid, gnt);
    end
  endtask

  task automatic test_all_fair();
    int cnt [NUM_REQ];
    int n;
    int cyc;
    for (int i = 0; i < NUM_REQ; i++) begin
      inp[i] = DATA_W'($urandom);
      cnt[i] = 0;
    end
    req = '1;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== inp[out_src]) begin
          errors++;
          $display("FAIL fair_data: src=%0d d=%0d want %0d", out_src,
                   out_data, inp[out_src]);
        end
        cnt[out_src]++;
        n++;
        if (n % 32 == 0) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            checks++;
            if (cnt[i] != 1) begin
              errors++;
              $display("FAIL fair_count[%0d]: got %0d grants want 1", i, cnt[i]);
            end
            cnt[i] = 0;
          end
        end
      end
      step();
      cyc++;
    end
    if (n < 64) begin
      checks++;
      errors++;
      $display("FAIL fair_timeout: got %0d transfers want 64", n);
    end
    req = '0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) inp[i] = '0;
    #1;
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_withdraw();
    test_all_fair();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
